// File: rtl/mem_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states,
// frame geometry constants and a small state-classification helper.
package mem_loader_pkg;

    // Loader FSM states, in the order a frame is processed
    typedef enum logic [3:0] {
        IDLE,
        HDR_AH,
        HDR_AL,
        HDR_CH,
        HDR_CL,
        DATA_H,
        DATA_L,
        SET_ADDR,
        WRITE,
        CHK,
        FINISH
    } state_t;

    // Header is ADDR_HI, ADDR_LO, CNT_HI, CNT_LO
    localparam int HDR_BYTES = 4;

    // Each memory word is sent as a high byte followed by a low byte
    localparam int BYTES_PER_WORD = 2;

    // States in which the loader is willing to take a byte from the receiver
    function automatic logic is_rx_state(input state_t s);
        return (s == HDR_AH) || (s == HDR_AL) || (s == HDR_CH) ||
               (s == HDR_CL) || (s == DATA_H) || (s == DATA_L) ||
               (s == CHK);
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Boot-time program loader. Receives a framed byte stream
// (address, count, then big-endian 16-bit words), writes the words to
// consecutive memory addresses using separate address-latch and write
// strobes, and holds busy high until the image is resident.
// Optional feature: define MEM_LOADER_CHECKSUM_EN to expect a trailing
// XOR checksum byte after the payload; a mismatch raises error.
// Every output is registered so the strobes are stable when the memory
// samples them on the falling edge.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_addr_en,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_in_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

`ifdef MEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CHK;
`else
    localparam state_t AFTER_LOAD = FINISH;
`endif

    state_t      state;
    state_t      next_state;

    logic [15:0] cur_addr;
    logic [15:0] cnt;
    logic [15:0] word;
    logic        xfer;

    logic              rx_ready_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic              mem_addr_en_n;
    logic [DATA_W-1:0] mem_in_n;
    logic              mem_in_en_n;
    logic              busy_n;
    logic              done_n;
    logic              error_n;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]  chk;
`endif

    assign xfer = rx_valid & rx_ready;

    // State register; reset abandons any load in progress
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: receive states wait for a byte, strobe states take one cycle each
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = HDR_AH;
            HDR_AH:   if (xfer)  next_state = HDR_AL;
            HDR_AL:   if (xfer)  next_state = HDR_CH;
            HDR_CH:   if (xfer)  next_state = HDR_CL;
            HDR_CL: begin
                if (xfer) begin
                    if ({cnt[15:8], rx_data} == 16'h0000) next_state = AFTER_LOAD;
                    else                                  next_state = DATA_H;
                end
            end
            DATA_H:   if (xfer)  next_state = DATA_L;
            DATA_L:   if (xfer)  next_state = SET_ADDR;
            SET_ADDR: next_state = WRITE;
            WRITE: begin
                if (cnt == 16'd1) next_state = AFTER_LOAD;
                else              next_state = DATA_H;
            end
            CHK:      if (xfer)  next_state = FINISH;
            FINISH:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the state being entered
    always_comb begin
        rx_ready_n    = is_rx_state(next_state);
        mem_addr_en_n = (next_state == SET_ADDR);
        mem_in_en_n   = (next_state == WRITE);
        busy_n        = (next_state != IDLE) && (next_state != FINISH);
        mem_addr_n    = mem_addr;
        mem_in_n      = mem_in;
        done_n        = done;
        error_n       = error;

        if (next_state == SET_ADDR) mem_addr_n = ADDR_W'(cur_addr);
        if (next_state == WRITE)    mem_in_n   = DATA_W'(word);

        if ((state == IDLE) && start) begin
            done_n  = 1'b0;
            error_n = 1'b0;
        end
        if (next_state == FINISH) done_n = 1'b1;

`ifdef MEM_LOADER_CHECKSUM_EN
        if ((state == CHK) && xfer && (chk != rx_data)) error_n = 1'b1;
`else
        error_n = 1'b0;
`endif
    end

    // Output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_ready    <= 1'b0;
            mem_addr    <= '0;
            mem_addr_en <= 1'b0;
            mem_in      <= '0;
            mem_in_en   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            rx_ready    <= rx_ready_n;
            mem_addr    <= mem_addr_n;
            mem_addr_en <= mem_addr_en_n;
            mem_in      <= mem_in_n;
            mem_in_en   <= mem_in_en_n;
            busy        <= busy_n;
            done        <= done_n;
            error       <= error_n;
        end
    end

    // Header capture, big-endian word assembly and address/count stepping after each write
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_addr <= 16'h0000;
            cnt      <= 16'h0000;
            word     <= 16'h0000;
        end else begin
            case (state)
                HDR_AH: if (xfer) cur_addr[15:8] <= rx_data;
                HDR_AL: if (xfer) cur_addr[7:0]  <= rx_data;
                HDR_CH: if (xfer) cnt[15:8]      <= rx_data;
                HDR_CL: if (xfer) cnt[7:0]       <= rx_data;
                DATA_H: if (xfer) word[15:8]     <= rx_data;
                DATA_L: if (xfer) word[7:0]      <= rx_data;
                WRITE: begin
                    cur_addr <= cur_addr + 16'd1;
                    cnt      <= cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    // Running XOR over every header and payload byte, restarted when a load begins
    always_ff @(posedge clk) begin
        if (!rst) begin
            chk <= 8'h00;
        end else if ((state == IDLE) && start) begin
            chk <= 8'h00;
        end else if (xfer && (state != CHK)) begin
            chk <= chk ^ rx_data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader. A behavioural memory on the
// falling edge records every write; the expected image is computed from
// the frame contents (word i lands at start address + i, modulo 2^16).
module tb_mem_loader;
    import mem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic        mem_addr_en;
    logic [15:0] mem_in;
    logic        mem_in_en;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] lat_addr = 16'h0000;
    logic        prev_addr_en = 1'b0;
    logic [15:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          addr_en_cnt = 0;
    int          rule_viol = 0;
    logic [15:0] load_words [$];

    always #5 clk = ~clk;

    mem_loader #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_addr_en(mem_addr_en),
        .mem_in(mem_in), .mem_in_en(mem_in_en), .busy(busy), .done(done), .error(error)
    );

    // Behavioural word memory plus strobe-rule monitor, sampling on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            if (mem_addr_en && mem_in_en) rule_viol++;
            if ((mem_addr_en || mem_in_en) && rx_ready) rule_viol++;
            if (mem_in_en && !prev_addr_en) rule_viol++;
            if (mem_addr_en) begin
                lat_addr = mem_addr;
                addr_en_cnt++;
            end
            if (mem_in_en) begin
                mem[lat_addr] = mem_in;
                wr_addr_q.push_back(lat_addr);
                wr_data_q.push_back(mem_in);
            end
            prev_addr_en = mem_addr_en;
        end else begin
            prev_addr_en = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memAt(input logic [15:0] a);
        if (mem.exists(a)) return {16'h0000, mem[a]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte after an idle gap and hold it until the loader takes it
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        logic acc;
        acc = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            acc = rx_ready;
            tick();
            if (acc) break;
        end
        rx_valid = 1'b0;
        if (!acc) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done && !busy) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Send one full frame from load_words and check strobes, status and memory image
    task automatic runLoad(input logic [15:0] addr, input int gap, input bit mid_start, input bit corrupt);
        logic [7:0]  bytes [$];
        logic [7:0]  csum;
        logic [15:0] a;
        int          n;
        n = load_words.size();
        wr_addr_q.delete();
        wr_data_q.delete();
        addr_en_cnt = 0;
        rule_viol   = 0;
        bytes.delete();
        bytes.push_back(addr[15:8]);
        bytes.push_back(addr[7:0]);
        bytes.push_back(8'(n >> 8));
        bytes.push_back(8'(n));
        foreach (load_words[i]) begin
            bytes.push_back(load_words[i][15:8]);
            bytes.push_back(load_words[i][7:0]);
        end
        csum = 8'h00;
        foreach (bytes[i]) csum = csum ^ bytes[i];
        checkOutput("frame_len", bytes.size(), HDR_BYTES + BYTES_PER_WORD * n);

        pulseStart();
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("done_cleared", {31'd0, done}, 32'd0);
        foreach (bytes[i]) begin
            if (mid_start && (i == HDR_BYTES + 1)) pulseStart();
            applyStimulus(bytes[i], gap);
        end
`ifndef MEM_LOADER_CHECKSUM_EN
        if (n == 0) begin
            tick();
            checkOutput("done_cnt0_2cyc", {31'd0, done}, 32'd1);
        end
`else
        applyStimulus(corrupt ? (csum ^ 8'h5A) : csum, gap);
`endif
        waitDone();
        checkOutput("done", {31'd0, done}, 32'd1);
        checkOutput("busy_end", {31'd0, busy}, 32'd0);
`ifdef MEM_LOADER_CHECKSUM_EN
        checkOutput("error", {31'd0, error}, {31'd0, corrupt});
`else
        checkOutput("error", {31'd0, error}, 32'd0);
`endif
        checkOutput("write_count", wr_addr_q.size(), n);
        checkOutput("addr_en_count", addr_en_cnt, n);
        for (int i = 0; i < n; i++) begin
            a = 16'(addr + 16'(i));
            if (i < wr_addr_q.size()) begin
                checkOutput("write_addr", {16'h0, wr_addr_q[i]}, {16'h0, a});
                checkOutput("write_data", {16'h0, wr_data_q[i]}, {16'h0, load_words[i]});
            end
            checkOutput("readback", memAt(a), {16'h0, load_words[i]});
        end
        checkOutput("strobe_rules", rule_viol, 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        tick();
        checkOutput("rx_ready_idle", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rx_ready"},    {31'd0, rx_ready}, 32'd0);
        checkOutput({tag, "_mem_addr"},    {16'd0, mem_addr}, 32'd0);
        checkOutput({tag, "_mem_addr_en"}, {31'd0, mem_addr_en}, 32'd0);
        checkOutput({tag, "_mem_in"},      {16'd0, mem_in}, 32'd0);
        checkOutput({tag, "_mem_in_en"},   {31'd0, mem_in_en}, 32'd0);
        checkOutput({tag, "_busy"},        {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"},        {31'd0, done}, 32'd0);
        checkOutput({tag, "_error"},       {31'd0, error}, 32'd0);
    endtask

    initial begin
        logic [15:0] w0;
        int          seen;

        rst = 1'b0;
        repeat (3) tick();
        checkAllZero("reset");
        rst = 1'b1;
        tick();

        $display("[TB] basic load");
        load_words = {16'h1234, 16'hABCD};
        runLoad(16'h0010, 0, 1'b0, 1'b0);

        $display("[TB] zero-count load");
        load_words.delete();
        runLoad(16'h0020, 0, 1'b0, 1'b0);

        $display("[TB] address wrap");
        load_words = {16'($urandom), 16'($urandom)};
        runLoad(16'hFFFF, 0, 1'b0, 1'b0);

        $display("[TB] gapped bytes with start while busy");
        load_words = {16'h1234, 16'hABCD};
        runLoad(16'h0010, 5, 1'b1, 1'b0);

        $display("[TB] reset after first write");
        w0 = 16'($urandom);
        wr_addr_q.delete();
        wr_data_q.delete();
        pulseStart();
        applyStimulus(8'h01, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(w0[15:8], 0);
        applyStimulus(w0[7:0], 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wr_addr_q.size() >= 1) begin
                seen = 1;
                break;
            end
        end
        checkOutput("first_write_seen", seen, 32'd1);
        #1 rst = 1'b0;
        tick();
        checkAllZero("midload_reset");
        checkOutput("midload_word0", memAt(16'h0100), {16'h0, w0});
        rst = 1'b1;
        tick();
        load_words = {16'($urandom), 16'($urandom), 16'($urandom)};
        runLoad(16'h0100, 0, 1'b0, 1'b0);

        $display("[TB] random loads");
        for (int r = 0; r < 4; r++) begin
            load_words.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) load_words.push_back(16'($urandom));
            runLoad(16'($urandom), int'($urandom_range(0, 3)), r[0], 1'b0);
        end

`ifdef MEM_LOADER_CHECKSUM_EN
        $display("[TB] corrupted checksum");
        load_words = {16'($urandom), 16'($urandom)};
        runLoad(16'h0400, 0, 1'b0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Boot-time program loader that sits directly upstream of the 16-bit word memory.
- Takes a byte stream (from the UART receiver) framed as a header and payload, and assembles big-endian 16-bit words.
- Drives the memory's address-latch/write strobes to store the words at consecutive addresses.
- Holds the CPU off (busy) until the image is resident.

Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 16, memory word width (fixed at 2 bytes per word; other values unsupported)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on posedge clk)
- start  in  1  1-cycle pulse; begins a load when in IDLE, ignored otherwise
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  received byte
- rx_ready  out  1  loader accepts rx_data this cycle (transfer = rx_valid & rx_ready)
- mem_addr  out  16  address to memory
- mem_addr_en  out  1  memory latches mem_addr into its address register on next negedge
- mem_in  out  16  write data to memory
- mem_in_en  out  1  memory writes mem_in at latched address on next negedge
- busy  out  1  load in progress
- done  out  1  sticky: last load completed; cleared by start
- error  out  1  sticky: last load failed (only with checksum feature); cleared by start

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; rx_ready=0, mem_addr=0, mem_addr_en=0, mem_in=0, mem_in_en=0, busy=0, done=0, error=0; internal addr/count/word regs=0. Reset mid-load abandons the load; any write already strobed stays in memory.
- All outputs are registered (driven from posedge) so strobes are stable across the memory's negedge sample.
- Frame: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words, each as HI byte then LO byte.
- States and transitions:
  - IDLE: busy=0. start -> HDR_AH, with busy=1, done=0, error=0.
  - HDR_AH, HDR_AL, HDR_CH, HDR_CL: rx_ready=1; each transfer stores its byte and advances. From HDR_CL: if CNT==0 -> FINISH, else -> DATA_H.
  - DATA_H: rx_ready=1; on transfer store the high byte -> DATA_L.
  - DATA_L: rx_ready=1; on transfer store the low byte -> SET_ADDR.
  - SET_ADDR: rx_ready=0; mem_addr=cur_addr, mem_addr_en=1 for exactly 1 cycle -> WRITE.
  - WRITE: rx_ready=0; mem_in=word, mem_in_en=1, mem_addr_en=0 for exactly 1 cycle. Then cur_addr+=1 (mod 2^16; 0xFFFF wraps to 0x0000) and cnt-=1. If cnt becomes 0 -> FINISH, else -> DATA_H.
  - FINISH: busy=0, done=1 -> IDLE.
- Strobe rules:
  - mem_addr_en and mem_in_en are never high in the same cycle.
  - mem_in_en is always preceded by exactly one mem_addr_en cycle carrying the same address.
- Throughput: at most one word per 4 cycles (2 byte transfers + SET_ADDR + WRITE); rx stalls in the strobe states.
- Byte gaps: rx_valid=0 in any receive state holds the state indefinitely. There is no timeout.
- start while busy is ignored.
- rx_valid while in IDLE or FINISH is not consumed (rx_ready=0).
- CNT may exceed the remaining address space; the address wraps and the load continues.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word (or after CNT_LO when CNT==0), a CHK state accepts one byte.
  - Expected value = XOR of all header and payload bytes.
  - Mismatch sets error=1 and done=1. Writes already performed are not undone.
- Undefined: no CHK state; error is tied 0.

Decomposition:
- Package mem_loader_pkg holds:
  - the state enum (IDLE, HDR_AH, HDR_AL, HDR_CH, HDR_CL, DATA_H, DATA_L, SET_ADDR, WRITE, CHK, FINISH);
  - the header byte-count constant (4);
  - the bytes-per-word constant (2).
- Sub-module: none required. Byte-to-word assembly stays inline; it is too small to justify a module.

Test Plan:
- Load addr=0x0010, cnt=2, bytes 12 34 AB CD -> mem_addr_en with 0x0010 then mem_in_en with 0x1234; mem_addr_en with 0x0011 then mem_in_en with 0xABCD; done=1, busy=0; memory read-back matches.
- cnt=0 (00 20 00 00) -> no strobes; done=1 two cycles after CNT_LO transfer.
- addr=0xFFFF, cnt=2 -> writes land at 0xFFFF and 0x0000.
- rx_valid gaps of 5 cycles between every byte, plus start pulsed mid-load -> identical memory result; start has no effect; rx_ready=0 in every SET_ADDR/WRITE cycle.
- rst=0 asserted after the first word write of a 3-word load -> all outputs 0 next posedge and state IDLE; a new start then runs a full load correctly.
- With MEM_LOADER_CHECKSUM_EN: correct XOR byte -> error=0; corrupted checksum byte -> error=1, done=1.
